// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  // Sequencer states: fetch A, fetch B, latch B, execute, write back.
  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StLdB,
    StExec,
    StWb
  } seq_state_e;

  // Bit positions inside the {Z, C, S, O} flag vector.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_O = 0;

  // ALU mode codes.
  localparam logic [3:0] ModeAdd  = 4'b0000;
  localparam logic [3:0] ModeSub  = 4'b0001;
  localparam logic [3:0] ModeNot  = 4'b0010;
  localparam logic [3:0] ModeShl  = 4'b0011;
  localparam logic [3:0] ModeAnd  = 4'b0100;
  localparam logic [3:0] ModeOr   = 4'b0101;
  localparam logic [3:0] ModeXor  = 4'b0110;
  localparam logic [3:0] ModeAddc = 4'b0111;
  localparam logic [3:0] ModeInc  = 4'b1000;
  localparam logic [3:0] ModeDec  = 4'b1001;
  localparam logic [3:0] ModeShr  = 4'b1010;
  localparam logic [3:0] ModeRor  = 4'b1011;
  localparam logic [3:0] ModeRol  = 4'b1100;
  localparam logic [3:0] ModeNand = 4'b1101;
  localparam logic [3:0] ModeNor  = 4'b1110;
  localparam logic [3:0] ModeNeg  = 4'b1111;

  // Modes whose C and O flags carry arithmetic meaning.
  function automatic logic is_carry_mode(input logic [3:0] mode);
    logic res;
    case (mode)
      ModeAdd, ModeSub, ModeAddc, ModeInc, ModeDec, ModeNeg: res = 1'b1;
      default:                                               res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_status_reg.sv
// Architectural status register {Z, C, S, O}.
// Optional feature macro: ALU_SEQ_FLAG_MASK_EN (keep C/O on non-carry modes).
module alu_status_reg
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] mode,
  input  logic [3:0] flags_in,
  output logic [3:0] sr_flags
);

  logic [3:0] flags_d, flags_q;

`ifndef ALU_SEQ_FLAG_MASK_EN
  logic unused_mode;
  assign unused_mode = ^mode;
`endif

  // Next flag value: hold unless loading; optionally mask C/O on logic modes.
  always_comb begin
    flags_d = flags_q;
    if (load) begin
`ifdef ALU_SEQ_FLAG_MASK_EN
      flags_d[FLAG_Z] = flags_in[FLAG_Z];
      flags_d[FLAG_S] = flags_in[FLAG_S];
      if (is_carry_mode(mode)) begin
        flags_d[FLAG_C] = flags_in[FLAG_C];
        flags_d[FLAG_O] = flags_in[FLAG_O];
      end
`else
      flags_d = flags_in;
`endif
    end
  end

  // Flag register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign sr_flags = flags_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle operand fetch / execute / write-back sequencer in front of the ALU.
// Optional feature macro: ALU_SEQ_FLAG_MASK_EN (handled in alu_status_reg).
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    mode,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_d,
  input  logic          wb_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_re,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_di,
  input  logic [DW-1:0] dmem_do,
  output logic          alu_e,
  output logic [3:0]    alu_mode,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  input  logic [DW-1:0] alu_out,
  input  logic [3:0]    alu_flags,
  output logic [3:0]    sr_flags
);

  seq_state_e    state_d, state_q;
  logic [3:0]    mode_d, mode_q;
  logic [AW-1:0] addr_a_d, addr_a_q, addr_b_d, addr_b_q, addr_d_d, addr_d_q;
  logic          wb_en_d, wb_en_q;
  logic [DW-1:0] op1_d, op1_q, op2_d, op2_q, result_d, result_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_d_d = addr_d_q;
    wb_en_d  = wb_en_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d   = mode;
          addr_a_d = addr_a;
          addr_b_d = addr_b;
          addr_d_d = addr_d;
          wb_en_d  = wb_en;
          state_d  = StRdA;
        end
      end
      StRdA: state_d = StRdB;
      // Data for addr_a arrives the cycle after its read strobe.
      StRdB: begin
        op1_d   = dmem_do;
        state_d = StLdB;
      end
      StLdB: begin
        op2_d   = dmem_do;
        state_d = StExec;
      end
      StExec: begin
        result_d = alu_out;
        state_d  = StWb;
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_d_q <= '0;
      wb_en_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_d_q <= addr_d_d;
      wb_en_q  <= wb_en_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
    end
  end

  // Memory strobes and ALU enable decoded from the current state.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StWb);
    dmem_addr = '0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    dmem_di   = '0;
    alu_e     = 1'b0;
    unique case (state_q)
      StRdA: begin
        dmem_addr = addr_a_q;
        dmem_re   = 1'b1;
      end
      StRdB: begin
        dmem_addr = addr_b_q;
        dmem_re   = 1'b1;
      end
      StExec: alu_e = 1'b1;
      StWb: begin
        if (wb_en_q) begin
          dmem_addr = addr_d_q;
          dmem_we   = 1'b1;
          dmem_di   = result_q;
        end
      end
      default: ;
    endcase
  end

  assign alu_mode = mode_q;
  assign alu_op1  = op1_q;
  assign alu_op2  = op2_q;

  alu_status_reg u_status_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == StExec),
    .mode     (mode_q),
    .flags_in (alu_flags),
    .sr_flags (sr_flags)
  );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a behavioural ALU and memory.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] mode;
  logic [7:0] addr_a, addr_b, addr_d;
  logic       wb_en;
  logic       busy, done, dmem_re, dmem_we, alu_e;
  logic [7:0] dmem_addr, dmem_di, dmem_do, alu_op1, alu_op2, alu_out;
  logic [3:0] alu_mode, alu_flags, sr_flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [3:0] ref_sr;
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_d    (addr_d),
    .wb_en     (wb_en),
    .busy      (busy),
    .done      (done),
    .dmem_addr (dmem_addr),
    .dmem_re   (dmem_re),
    .dmem_we   (dmem_we),
    .dmem_di   (dmem_di),
    .dmem_do   (dmem_do),
    .alu_e     (alu_e),
    .alu_mode  (alu_mode),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .sr_flags  (sr_flags)
  );

  // Behavioural ALU: returns {Z, C, S, O, result}. Logic modes present junk C/O.
  function automatic logic [11:0] alu_fn(input logic [3:0] m, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, o;
    c = a[0] ^ b[7];
    o = a[7] & b[0];
    r = 8'h00;
    w = 9'h000;
    case (m)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; c = (a >= b); o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd7: begin w = {1'b0, a} + {1'b0, b} + 9'd1; r = w[7:0]; c = w[8];
                  o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd8: begin r = a + 8'd1; c = (a == 8'hFF); o = (a == 8'h7F); end
      4'd9: begin r = a - 8'd1; c = (a != 8'h00); o = (a == 8'h80); end
      4'd15: begin r = 8'h00 - a; c = (a == 8'h00); o = (a == 8'h80); end
      4'd2:  r = ~a;
      4'd3:  r = {a[6:0], 1'b0};
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd10: r = {1'b0, a[7:1]};
      4'd11: r = {a[0], a[7:1]};
      4'd12: r = {a[6:0], a[7]};
      4'd13: r = ~(a & b);
      default: r = ~(a | b);
    endcase
    return {(r == 8'h00), c, r[7], o, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_fn(alu_mode, alu_op1, alu_op2);

  // Single-port memory with one-cycle read latency plus a bench preload path.
  always @(posedge clk) begin
    if (dmem_we)    mem[dmem_addr] <= dmem_di;
    else if (ld_en) mem[ld_addr]   <= ld_data;
    if (dmem_re)    dmem_do        <= mem[dmem_addr];
  end

  // Reference model of one whole operation.
  task automatic ref_op(input logic [3:0] m, input logic [7:0] aa, input logic [7:0] ab,
                        input logic [7:0] ad, input logic wb);
    logic [11:0] fr;
    logic        no_carry;
    fr = alu_fn(m, ref_mem[aa], ref_mem[ab]);
    no_carry = (m >= 4'd2 && m <= 4'd6) || (m >= 4'd10 && m <= 4'd14);
`ifdef ALU_SEQ_FLAG_MASK_EN
    if (no_carry) ref_sr = {fr[11], ref_sr[2], fr[9], ref_sr[0]};
    else          ref_sr = fr[11:8];
`else
    if (no_carry || !no_carry) ref_sr = fr[11:8];
`endif
    if (wb) ref_mem[ad] = fr[7:0];
  endtask

  task automatic mem_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Issues one start and observes cycles k+1..k+7; counts protocol anomalies.
  task automatic run_op(input logic [3:0] m, input logic [7:0] aa, input logic [7:0] ab,
                        input logic [7:0] ad, input logic wb, output int done_cyc,
                        output int done_cnt, output int we_cnt, output int bad);
    logic [3:0] prev_sr;
    done_cyc = 0; done_cnt = 0; we_cnt = 0; bad = 0;
    @(negedge clk);
    mode = m; addr_a = aa; addr_b = ab; addr_d = ad; wb_en = wb; start = 1'b1;
    prev_sr = sr_flags;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 4'($urandom); addr_a = 8'($urandom); addr_b = 8'($urandom);
    addr_d = 8'($urandom); wb_en = 1'($urandom);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (done) begin done_cnt++; done_cyc = c; end
      if (dmem_we) begin we_cnt++; if (dmem_addr !== ad) bad++; end
      if (dmem_re && dmem_we) bad++;
      if (alu_e !== (c == 4)) bad++;
      if (busy !== (c <= 5)) bad++;
      if (dmem_re !== (c == 1 || c == 2)) bad++;
      if (c == 1 && dmem_addr !== aa) bad++;
      if (c == 2 && dmem_addr !== ab) bad++;
      if (sr_flags !== prev_sr && c != 5) bad++;
      prev_sr = sr_flags;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mode = 4'h0; addr_a = 8'h00; addr_b = 8'h00;
    addr_d = 8'h00; wb_en = 1'b0; ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    ref_sr = 4'b0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, dmem_re, dmem_we, alu_e} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, dmem_re, dmem_we, alu_e});
    end
    n_checks++;
    if ({dmem_addr, dmem_di} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mem_bus: got %h want 0000", {dmem_addr, dmem_di});
    end
    n_checks++;
    if ({alu_mode, alu_op1, alu_op2} !== 20'h00000) begin
      n_fail++; $display("FAIL reset_alu_regs: got %h want 00000", {alu_mode, alu_op1, alu_op2});
    end
    n_checks++;
    if (sr_flags !== 4'b0000) begin
      n_fail++; $display("FAIL reset_sr: got %b want 0000", sr_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mem_load(8'(i), 8'($urandom));
  endtask

  task automatic test_add_overflow;
    int dc, dn, wc, bad;
    mem_load(8'h10, 8'h7F); mem_load(8'h11, 8'h01);
    run_op(4'b0000, 8'h10, 8'h11, 8'h12, 1'b1, dc, dn, wc, bad);
    ref_op(4'b0000, 8'h10, 8'h11, 8'h12, 1'b1);
    n_checks++;
    if (mem[8'h12] !== 8'h80) begin
      n_fail++; $display("FAIL add_result: got %h want 80", mem[8'h12]);
    end
    n_checks++;
    if (sr_flags !== 4'b0011) begin
      n_fail++; $display("FAIL add_flags: got %b want 0011", sr_flags);
    end
    n_checks++;
    if (dc !== 5 || dn !== 1) begin
      n_fail++; $display("FAIL add_done_timing: got cycle %0d count %0d want 5/1", dc, dn);
    end
    n_checks++;
    if (wc !== 1 || bad !== 0) begin
      n_fail++; $display("FAIL add_protocol: got writes %0d anomalies %0d want 1/0", wc, bad);
    end
  endtask

  task automatic test_sub_zero;
    int dc, dn, wc, bad;
    mem_load(8'h20, 8'h05); mem_load(8'h21, 8'h05);
    run_op(4'b0001, 8'h20, 8'h21, 8'h22, 1'b1, dc, dn, wc, bad);
    ref_op(4'b0001, 8'h20, 8'h21, 8'h22, 1'b1);
    n_checks++;
    if (mem[8'h22] !== 8'h00 || sr_flags !== 4'b1100) begin
      n_fail++; $display("FAIL sub_zero: got %h/%b want 00/1100", mem[8'h22], sr_flags);
    end
    n_checks++;
    if (bad !== 0 || dc !== 5) begin
      n_fail++; $display("FAIL sub_protocol: got anomalies %0d done %0d want 0/5", bad, dc);
    end
  endtask

  task automatic test_flag_mask;
    int dc, dn, wc, bad;
    mem_load(8'h24, 8'hF0); mem_load(8'h25, 8'h0F);
    run_op(4'b0100, 8'h24, 8'h25, 8'h26, 1'b1, dc, dn, wc, bad);
    ref_op(4'b0100, 8'h24, 8'h25, 8'h26, 1'b1);
    n_checks++;
    if (sr_flags !== ref_sr) begin
      n_fail++; $display("FAIL flag_mask: got %b want %b", sr_flags, ref_sr);
    end
    n_checks++;
    if (sr_flags[3] !== 1'b1 || sr_flags[1] !== 1'b0 || mem[8'h26] !== 8'h00) begin
      n_fail++; $display("FAIL and_zs: got %b/%h want Z1 S0 result 00", sr_flags, mem[8'h26]);
    end
  endtask

  task automatic test_no_writeback;
    int dc, dn, wc, bad;
    mem_load(8'h50, 8'hFF); mem_load(8'h51, 8'h3C);
    run_op(4'b1000, 8'h50, 8'h51, 8'h50, 1'b0, dc, dn, wc, bad);
    ref_op(4'b1000, 8'h50, 8'h51, 8'h50, 1'b0);
    n_checks++;
    if (wc !== 0 || mem[8'h50] !== 8'hFF) begin
      n_fail++; $display("FAIL nowb_write: got writes %0d mem %h want 0/ff", wc, mem[8'h50]);
    end
    n_checks++;
    if (sr_flags[3:2] !== 2'b11 || sr_flags !== ref_sr) begin
      n_fail++; $display("FAIL nowb_flags: got %b want %b", sr_flags, ref_sr);
    end
    n_checks++;
    if (dn !== 1 || dc !== 5) begin
      n_fail++; $display("FAIL nowb_done: got count %0d cycle %0d want 1/5", dn, dc);
    end
  endtask

  task automatic test_start_held;
    logic [14:1] busy_bits, done_bits, exp_busy, exp_done;
    int          wc;
    wc = 0;
    mem_load(8'h40, 8'h80); mem_load(8'h41, 8'h80);
    @(negedge clk);
    mode = 4'b0000; addr_a = 8'h40; addr_b = 8'h41; addr_d = 8'h42; wb_en = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      busy_bits[c] = busy;
      done_bits[c] = done;
      exp_busy[c]  = (c <= 5) || (c >= 7 && c <= 11);
      exp_done[c]  = (c == 5) || (c == 11);
      if (dmem_we) wc++;
      if (c == 7) start = 1'b0;
      if (c == 8) start = 1'b1;
      if (c == 9) start = 1'b0;
    end
    ref_op(4'b0000, 8'h40, 8'h41, 8'h42, 1'b1);
    ref_op(4'b0000, 8'h40, 8'h41, 8'h42, 1'b1);
    n_checks++;
    if (busy_bits !== exp_busy) begin
      n_fail++; $display("FAIL held_busy: got %b want %b", busy_bits, exp_busy);
    end
    n_checks++;
    if (done_bits !== exp_done) begin
      n_fail++; $display("FAIL held_done: got %b want %b", done_bits, exp_done);
    end
    n_checks++;
    if (wc !== 2 || mem[8'h42] !== ref_mem[8'h42] || sr_flags !== ref_sr) begin
      n_fail++; $display("FAIL held_result: got w%0d %h %b want 2 %h %b", wc, mem[8'h42],
                         sr_flags, ref_mem[8'h42], ref_sr);
    end
  endtask

  task automatic test_reset_mid_op;
    int dc, dn, wc, bad, late_we, late_done;
    late_we = 0; late_done = 0;
    mem_load(8'h30, 8'h12); mem_load(8'h31, 8'h34); mem_load(8'h32, 8'hAA);
    @(negedge clk);
    mode = 4'b0000; addr_a = 8'h30; addr_b = 8'h31; addr_d = 8'h32; wb_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (alu_e !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_exec: got alu_e %b want 1", alu_e);
    end
    #2 rst_n = 1'b0;
    #1;
    ref_sr = 4'b0000;
    n_checks++;
    if ({busy, alu_e, done, sr_flags} !== 7'b0000000) begin
      n_fail++; $display("FAIL midrst_state: got %b want 0000000", {busy, alu_e, done, sr_flags});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (dmem_we) late_we++;
      if (done) late_done++;
    end
    n_checks++;
    if (late_we !== 0 || late_done !== 0 || mem[8'h32] !== 8'hAA) begin
      n_fail++; $display("FAIL midrst_no_wb: got we %0d done %0d mem %h want 0 0 aa",
                         late_we, late_done, mem[8'h32]);
    end
    run_op(4'b0000, 8'h30, 8'h31, 8'h32, 1'b1, dc, dn, wc, bad);
    ref_op(4'b0000, 8'h30, 8'h31, 8'h32, 1'b1);
    n_checks++;
    if (mem[8'h32] !== 8'h46 || sr_flags !== ref_sr || bad !== 0 || dc !== 5) begin
      n_fail++; $display("FAIL midrst_recover: got %h %b bad%0d done%0d want 46 %b 0 5",
                         mem[8'h32], sr_flags, bad, dc, ref_sr);
    end
  endtask

  task automatic test_random;
    int         dc, dn, wc, bad;
    logic [3:0] m;
    logic [7:0] aa, ab, ad;
    logic       wb;
    for (int i = 0; i < 24; i++) begin
      m  = 4'($urandom);
      aa = 8'h80 | 8'($urandom_range(0, 7));
      ab = 8'h80 | 8'($urandom_range(0, 7));
      ad = 8'h80 | 8'($urandom_range(0, 7));
      wb = 1'($urandom);
      run_op(m, aa, ab, ad, wb, dc, dn, wc, bad);
      ref_op(m, aa, ab, ad, wb);
      n_checks++;
      if (sr_flags !== ref_sr) begin
        n_fail++; $display("FAIL rnd_flags[%0d] mode %h: got %b want %b", i, m, sr_flags, ref_sr);
      end
      n_checks++;
      if (mem[ad] !== ref_mem[ad]) begin
        n_fail++; $display("FAIL rnd_mem[%0d] mode %h: got %h want %h", i, m, mem[ad], ref_mem[ad]);
      end
      n_checks++;
      if (dc !== 5 || dn !== 1 || wc !== int'(wb) || bad !== 0) begin
        n_fail++; $display("FAIL rnd_protocol[%0d]: got done%0d/%0d we%0d bad%0d want 5/1/%0d/0",
                           i, dc, dn, wc, bad, wb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_flag_mask();
    test_no_writeback();
    test_start_held();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
